// File: rtl/zap_uart_stim_pkg.sv
// Shared types and constants for the bench-side UART stimulus transmitter.
package zap_uart_stim_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Cycles from the first START cycle to the last GAP cycle of one frame.
    function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                                 input int unsigned stop_bits,
                                                 input int unsigned gap_bits);
        return (32'd9 + stop_bits + gap_bits) * clk_div;
    endfunction

endpackage

// File: rtl/zap_uart_stim_fifo.sv
// Single-clock byte FIFO; the head entry is presented on o_data whenever the
// FIFO is non-empty, so a pop needs no read latency.
module zap_uart_stim_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_ready,
    output logic [LVL_W-1:0] o_level
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             push_ok_s, pop_ok_s;

    // A pop on the same edge frees the head slot, so a push into a full FIFO is taken then.
    always_comb begin
        pop_ok_s  = i_pop && (level_q != {LVL_W{1'b0}});
        push_ok_s = i_push && ((level_q != FULL_LVL) || pop_ok_s);
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        if (push_ok_s && !pop_ok_s) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            level_d = level_q - LVL_W'(1);
        end else begin
            level_d = level_q;
        end
        ready_d = (level_d != FULL_LVL);
    end

    // Pointer, occupancy and ready registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge i_clk) begin
        if (push_ok_s && !i_reset) begin
            mem_q[wr_ptr_q] <= i_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_empty = (level_q == {LVL_W{1'b0}});
    assign o_ready = ready_q;
    assign o_level = level_q;

endmodule

// File: rtl/zap_uart_stim_tx.sv
// Bench-side UART serializer: buffers pushed bytes and emits 8N1/8N2 frames,
// LSB first, followed by a fixed idle gap.
module zap_uart_stim_tx
    import zap_uart_stim_pkg::*;
#(
    parameter  int CLK_DIV        = 16,
    parameter  int FIFO_DEPTH     = 16,
    parameter  int STOP_BITS      = 1,
    parameter  int GAP_BITS       = 118,
    parameter  int INIT_IDLE_BITS = 255,
    localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_line,
    output logic             o_busy,
    output logic [LVL_W-1:0] o_level,
    output logic             o_frame_done
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int MAX_A    = (INIT_IDLE_BITS > GAP_BITS) ? INIT_IDLE_BITS : GAP_BITS;
    localparam int MAX_B    = (STOP_BITS > 8) ? STOP_BITS : 8;
    localparam int MAX_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'((INIT_IDLE_BITS > 0) ? INIT_IDLE_BITS - 1 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] bit_last_s;
    logic             div_tc_s, step_s, pop_s, fifo_empty_s;
    logic [7:0]       fifo_data_s;

    zap_uart_stim_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_byte_valid),
        .i_data  (i_byte),
        .i_pop   (pop_s),
        .o_data  (fifo_data_s),
        .o_empty (fifo_empty_s),
        .o_ready (o_byte_ready),
        .o_level (o_level)
    );

    // State, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= INIT;
            div_q   <= {DIV_W{1'b0}};
            bit_q   <= {CNT_W{1'b0}};
            shift_q <= 8'h00;
            line_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: each timed state ends on the terminal divider count of its last bit-time.
    always_comb begin
        case (state_q)
            INIT:    bit_last_s = INIT_LAST;
            DATA:    bit_last_s = DATA_LAST;
            STOP:    bit_last_s = STOP_LAST;
            GAP:     bit_last_s = GAP_LAST;
            default: bit_last_s = {CNT_W{1'b0}};
        endcase
        div_tc_s = (div_q == DIV_LAST);
        step_s   = div_tc_s && (bit_q == bit_last_s);
        pop_s    = (state_q == IDLE) && !fifo_empty_s;

        if ((state_q == IDLE) || div_tc_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if ((state_q == IDLE) || step_s) begin
            bit_d = {CNT_W{1'b0}};
        end else if (div_tc_s) begin
            bit_d = bit_q + CNT_W'(1);
        end else begin
            bit_d = bit_q;
        end

        if (pop_s) begin
            shift_d = fifo_data_s;
        end else if ((state_q == DATA) && div_tc_s) begin
            shift_d = {1'b0, shift_q[7:1]};
        end else begin
            shift_d = shift_q;
        end

        case (state_q)
            INIT:    state_d = step_s ? IDLE : INIT;
            IDLE:    state_d = fifo_empty_s ? IDLE : START;
            START:   state_d = step_s ? DATA : START;
            DATA:    state_d = step_s ? STOP : DATA;
            STOP:    state_d = step_s ? ((GAP_BITS == 0) ? IDLE : GAP) : STOP;
            GAP:     state_d = step_s ? IDLE : GAP;
            default: state_d = INIT;
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes with the state.
    always_comb begin
        case (state_d)
            START:   line_d = START_LEVEL;
            DATA:    line_d = shift_d[0];
            default: line_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d == START) || (state_d == DATA) ||
                 (state_d == STOP)  || (state_d == GAP);
        done_d = (div_d == DIV_LAST) &&
                 (((state_d == GAP) && (bit_d == GAP_LAST)) ||
                  ((GAP_BITS == 0) && (state_d == STOP) && (bit_d == STOP_LAST)));
    end

    assign o_line       = line_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_zap_uart_stim_tx.sv
// Directed bench for zap_uart_stim_tx: three instances cover the default
// configuration, a 4-deep FIFO, and 2 stop bits with no gap.
module tb_zap_uart_stim_tx;
    import zap_uart_stim_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst_a, a_valid, a_ready, a_line, a_busy, a_done;
    logic [7:0] a_byte;
    logic [4:0] a_level;
    logic       rst_b, b_valid, b_ready, b_line, b_busy, b_done;
    logic [7:0] b_byte;
    logic [2:0] b_level;
    logic       rst_c, c_valid, c_ready, c_line, c_busy, c_done;
    logic [7:0] c_byte;
    logic [4:0] c_level;

    zap_uart_stim_tx u_dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_byte(a_byte), .i_byte_valid(a_valid),
        .o_byte_ready(a_ready), .o_line(a_line), .o_busy(a_busy),
        .o_level(a_level), .o_frame_done(a_done)
    );

    zap_uart_stim_tx #(
        .CLK_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(1), .GAP_BITS(2), .INIT_IDLE_BITS(20)
    ) u_dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_byte(b_byte), .i_byte_valid(b_valid),
        .o_byte_ready(b_ready), .o_line(b_line), .o_busy(b_busy),
        .o_level(b_level), .o_frame_done(b_done)
    );

    zap_uart_stim_tx #(
        .CLK_DIV(8), .FIFO_DEPTH(16), .STOP_BITS(2), .GAP_BITS(0), .INIT_IDLE_BITS(4)
    ) u_dut_c (
        .i_clk(clk), .i_reset(rst_c), .i_byte(c_byte), .i_byte_valid(c_valid),
        .o_byte_ready(c_ready), .o_line(c_line), .o_busy(c_busy),
        .o_level(c_level), .o_frame_done(c_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial receiver: samples mid-bit on the selected line.
    logic       mon_en  = 1'b0;
    int         mon_sel = 0;
    int         mon_div = 16;
    logic       mon_line;
    logic [7:0] rx_b;
    logic [7:0] rx_q [$];

    always_comb mon_line = (mon_sel == 1) ? b_line : ((mon_sel == 2) ? c_line : a_line);

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && (mon_line === 1'b0)) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    rx_b[i] = mon_line;
                end
                repeat (mon_div) @(negedge clk);
                check_eq("rx_stop_bit", {31'd0, mon_line}, 32'd1);
                rx_q.push_back(rx_b);
            end
        end
    end

    initial begin
        logic [9:0] pat55;
        logic [9:0] bit_ok;
        logic       gap_ok, high_ok, prev;
        int         done_n, done_at, first0, run;
        string      exp_s;
        logic [7:0] b_vec [6];
        logic [7:0] b_exp [5];
        logic [7:0] c_vec [3];
        int         runs [$];
        int         falls [$];
        int         dones [$];

        pat55 = 10'b1010101010;
        b_vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        b_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
        c_vec = '{8'hFF, 8'h00, 8'hFF};
        exp_s = "DLROW OLLEH ";
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_byte = 8'h00; b_byte = 8'h00; c_byte = 8'h00;
        tick();
        tick();
        rst_b = 1'b0;

        // FIFO_DEPTH=4: reset values, overflow drop, push on the pop edge while full
        check_eq("b_rst_line", {31'd0, b_line}, 32'd1);
        check_eq("b_rst_level", {29'd0, b_level}, 32'd0);
        check_eq("b_rst_ready", {31'd0, b_ready}, 32'd1);
        check_eq("b_rst_busy", {31'd0, b_busy}, 32'd0);
        mon_sel = 1; mon_div = 4; rx_q.delete(); mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1; b_byte = b_vec[i]; tick();
        end
        check_eq("b_full_level", {29'd0, b_level}, 32'd4);
        check_eq("b_full_ready", {31'd0, b_ready}, 32'd0);
        for (int i = 4; i < 6; i++) begin
            b_valid = 1'b1; b_byte = b_vec[i]; tick();
        end
        b_valid = 1'b0;
        check_eq("b_drop_level", {29'd0, b_level}, 32'd4);
        check_eq("b_drop_ready", {31'd0, b_ready}, 32'd0);
        repeat (74) tick();
        b_valid = 1'b1; b_byte = 8'h77; tick();
        b_valid = 1'b0;
        check_eq("b_pushpop_level", {29'd0, b_level}, 32'd4);
        check_eq("b_pushpop_line", {31'd0, b_line}, 32'd0);
        done_n = 0;
        for (int k = 0; k < 600 && done_n < 5; k++) begin
            tick();
            if (b_done) done_n++;
        end
        check_eq("b_done_count", done_n, 32'd5);
        check_eq("b_rx_count", rx_q.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("b_rx_byte%0d", i),
                     (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF, {24'd0, b_exp[i]});
        check_eq("b_end_level", {29'd0, b_level}, 32'd0);
        check_eq("b_end_ready", {31'd0, b_ready}, 32'd1);
        mon_en = 1'b0;

        // STOP_BITS=2, GAP_BITS=0: frame length and inter-frame spacing
        rst_c = 1'b1; tick(); rst_c = 1'b0;
        mon_sel = 2; mon_div = 8; rx_q.delete(); mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_valid = 1'b1; c_byte = c_vec[i]; tick();
        end
        c_valid = 1'b0;
        prev = 1'b1; run = 0;
        for (int k = 0; k < 320; k++) begin
            if (c_line === 1'b1) begin
                run++;
            end else begin
                if (prev === 1'b1) begin
                    runs.push_back(run);
                    falls.push_back(k);
                end
                run = 0;
            end
            prev = c_line;
            if (c_done) dones.push_back(k);
            tick();
        end
        check_eq("c_fall_count", falls.size(), 32'd3);
        check_eq("c_high_run_ff", (runs.size() > 1) ? runs[1] : -1, 32'd81);
        check_eq("c_high_run_00", (runs.size() > 2) ? runs[2] : -1, 32'd17);
        check_eq("c_done_count", dones.size(), 32'd3);
        check_eq("c_frame_len", (dones.size() > 0 && falls.size() > 0) ? dones[0] - falls[0] + 1 : -1,
                 frame_cycles(8, 2, 0));
        check_eq("c_frame_spacing", (falls.size() > 1) ? falls[1] - falls[0] : -1, 32'd89);
        check_eq("c_rx_count", rx_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("c_rx_byte%0d", i),
                     (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF, {24'd0, c_vec[i]});
        mon_en = 1'b0;

        // Default instance: reset, init idle window, 0x55 waveform
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        check_eq("a_rst_line", {31'd0, a_line}, 32'd1);
        check_eq("a_rst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("a_rst_level", {27'd0, a_level}, 32'd0);
        check_eq("a_rst_done", {31'd0, a_done}, 32'd0);
        check_eq("a_rst_ready", {31'd0, a_ready}, 32'd1);
        high_ok = 1'b1;
        for (int k = 1; k < 4100; k++) begin
            tick();
            if (a_line !== 1'b1) high_ok = 1'b0;
        end
        check_eq("a_init_idle", {31'd0, high_ok}, 32'd1);
        a_valid = 1'b1; a_byte = 8'h55; tick();
        a_valid = 1'b0; a_byte = 8'hAA;
        check_eq("a_push_level", {27'd0, a_level}, 32'd1);
        check_eq("a_push_line", {31'd0, a_line}, 32'd1);
        tick();
        check_eq("a_start_busy", {31'd0, a_busy}, 32'd1);
        check_eq("a_start_level", {27'd0, a_level}, 32'd0);
        bit_ok = 10'h3FF; gap_ok = 1'b1; done_n = 0; done_at = -1;
        for (int k = 0; k < 2048; k++) begin
            if (k < 160) begin
                if (a_line !== pat55[k / 16]) bit_ok[k / 16] = 1'b0;
            end else begin
                if (a_line !== 1'b1) gap_ok = 1'b0;
            end
            if (a_done) begin
                done_n++;
                done_at = k;
            end
            tick();
        end
        for (int b = 0; b < 10; b++)
            check_eq($sformatf("a_55_bit%0d", b), {31'd0, bit_ok[b]}, 32'd1);
        check_eq("a_gap_high", {31'd0, gap_ok}, 32'd1);
        check_eq("a_done_once", done_n, 32'd1);
        check_eq("a_done_cycle", done_at, 32'd2047);
        check_eq("a_idle_busy", {31'd0, a_busy}, 32'd0);

        // Twelve back-to-back bytes decoded in order
        mon_sel = 0; mon_div = 16; rx_q.delete(); mon_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_valid = 1'b1; a_byte = exp_s[i]; tick();
        end
        a_valid = 1'b0;
        check_eq("a_burst_level", {27'd0, a_level}, 32'd11);
        done_n = 0;
        for (int k = 0; k < 24700 && done_n < 12; k++) begin
            tick();
            if (a_done) done_n++;
        end
        check_eq("a_burst_done", done_n, 32'd12);
        check_eq("a_burst_rx_count", rx_q.size(), 32'd12);
        for (int i = 0; i < 12; i++)
            check_eq($sformatf("a_burst_byte%0d", i),
                     (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF, {24'd0, exp_s[i]});
        check_eq("a_burst_end_level", {27'd0, a_level}, 32'd0);
        mon_en = 1'b0;

        // Reset in DATA bit 3 of 0xA3 abandons the frame and re-enters the idle window
        a_valid = 1'b1; a_byte = 8'hA3; tick();
        a_byte = 8'h11; tick();
        a_valid = 1'b0;
        repeat (70) tick();
        check_eq("a_a3_bit3", {31'd0, a_line}, 32'd0);
        check_eq("a_a3_level", {27'd0, a_level}, 32'd1);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        check_eq("a_midrst_line", {31'd0, a_line}, 32'd1);
        check_eq("a_midrst_level", {27'd0, a_level}, 32'd0);
        check_eq("a_midrst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("a_midrst_ready", {31'd0, a_ready}, 32'd1);
        a_valid = 1'b1; a_byte = 8'h3C; tick();
        a_valid = 1'b0;
        check_eq("a_init_push_level", {27'd0, a_level}, 32'd1);
        first0 = -1; done_n = 0;
        for (int k = 1; k <= 4100; k++) begin
            if ((a_line !== 1'b1) && (first0 < 0)) first0 = k;
            if (a_done) done_n++;
            tick();
        end
        check_eq("a_midrst_first_start", first0, 32'd4081);
        check_eq("a_midrst_no_done", done_n, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
